apb_master_bridge: RTL and testbench

//  APB requester that sits directly upstream of the APB slave. It turns a simple

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master_bridge.sv | 140 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase encoding and default bus widths,
// used by the requester bridge, the slave and the benches.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_DATA_SIZE = 32;
  localparam int APB_ADDR_SIZE = 10;

endpackage

// File: rtl/apb_master_bridge.sv
// APB requester: converts a valid/ready command stream into IDLE->SETUP->ACCESS
// transfers and returns read data / error status through a one-entry response slot.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int DATA_SIZE      = APB_DATA_SIZE,
  parameter int ADDR_SIZE      = APB_ADDR_SIZE,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  // Both streams: a beat transfers on a rising pclk where valid & ready are both
  // high; the offering side keeps valid and its payload steady until then.
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [DATA_SIZE-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDR_SIZE-1:0] paddr,
  output logic [DATA_SIZE-1:0] pwdata,
  output logic                 pbusy,
  input  logic                 pready,
  input  logic [DATA_SIZE-1:0] prdata,
  input  logic                 pslverr,
  output logic [1:0]           o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  apb_state_t           r_state;
  apb_state_t           w_state_nxt;
  logic                 w_accept;
  logic                 w_complete;
  logic                 w_timeout;
  logic                 w_cmd_ready;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_pbusy;
  logic                 r_psel;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [ADDR_SIZE-1:0] r_paddr;
  logic [DATA_SIZE-1:0] r_pwdata;
  logic                 r_rsp_valid;
  logic [DATA_SIZE-1:0] r_rsp_rdata;
  logic                 r_rsp_err;

  // A slot being drained this very cycle counts as free, so accept and consume overlap.
  assign w_cmd_ready = (r_state == APB_IDLE) && !r_pbusy && (!r_rsp_valid || rsp_ready);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= APB_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      APB_IDLE: begin
        if (w_cmd_ready && cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = APB_SETUP;
        end
      end
      APB_SETUP: w_state_nxt = APB_ACCESS;
      APB_ACCESS: begin
        if (pready) begin
          w_complete  = 1'b1;
          w_state_nxt = APB_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_complete  = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = APB_IDLE;
        end
      end
      default: w_state_nxt = APB_IDLE;
    endcase
  end

  // APB strobes are registered from the next state so they align with the phase.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_pbusy     <= 1'b1;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_pbusy   <= 1'b0;
      r_psel    <= (w_state_nxt != APB_IDLE);
      r_penable <= (w_state_nxt == APB_ACCESS);
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end
      if (r_state == APB_SETUP) begin
        r_cnt <= '0;
      end else if (r_state == APB_ACCESS && !pready && r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_complete) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_timeout || pslverr;
        r_rsp_rdata <= (w_timeout || pslverr || r_pwrite) ? '0 : prdata;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pbusy       = r_pbusy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: scripted APB slave with a small memory,
// response scoreboard fed at command time, APB phase monitor and a final report.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic          pclk = 1'b0;
  logic          presetn;
  always #5 pclk = ~pclk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pbusy, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic [1:0]    dbg_state;

  apb_master_bridge #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pbusy(pbusy), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .o_dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int            checks = 0;
  int            errors = 0;
  logic [32:0]   exp_q[$];          // {err, rdata}
  logic [DW-1:0] mem [1024];
  logic [AW-1:0] wr_log[$];
  int            sl_wait  = 0;
  bit            sl_err   = 1'b0;
  bit            sl_never = 1'b0;
  int            sl_cnt   = 0;
  int            acc_run  = 0;
  int            acc_len  = 0;
  int            setup_cnt = 0;
  logic [AW-1:0] su_addr;
  logic          su_write;
  logic [DW-1:0] su_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scripted APB slave ----------------
  // Outside ACCESS it drives pready/pslverr high to show the bridge ignores them there.
  always @(negedge pclk) begin
    if (psel && penable) begin
      if (!sl_never && sl_cnt >= sl_wait) begin
        pready  = 1'b1;
        pslverr = sl_err;
        prdata  = sl_err ? '0 : (pwrite ? 32'hBAD0_0BAD : mem[paddr]);
        if (pwrite && !sl_err) begin
          mem[paddr] = pwdata;
          wr_log.push_back(paddr);
        end
      end else begin
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = 32'h5555_5555;
        sl_cnt++;
      end
    end else begin
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = '1;
      sl_cnt  = 0;
    end
  end

  // ---------------- scoreboard + APB monitor ----------------
  always @(negedge pclk) begin : mon
    logic [32:0] e;
    if (presetn) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_err", rsp_err, e[32]);
          chk("rsp_rdata", rsp_rdata, e[31:0]);
        end
      end
      if (psel && !penable) begin
        su_addr  = paddr;
        su_write = pwrite;
        su_wdata = pwdata;
        setup_cnt++;
      end
      if (psel && penable) begin
        acc_run++;
        chk("access_paddr_stable", paddr, su_addr);
        chk("access_pwrite_stable", pwrite, su_write);
        chk("access_pwdata_stable", pwdata, su_wdata);
      end else if (acc_run != 0) begin
        acc_len = acc_run;
        acc_run = 0;
      end
    end else begin
      acc_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [32:0] e);
    int n;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    exp_q.push_back(e);
    n = 0;
    @(negedge pclk);
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge pclk);
    end
    chk("cmd_accept", cmd_ready, 1);
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !rsp_valid) break;
      @(posedge pclk);
      #1;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s0;
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    presetn   = 1'b0;
    repeat (3) @(posedge pclk);
    #1;

    // reset state and release
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pbusy", pbusy, 1);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_state", dbg_state, APB_IDLE);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rel_pbusy_held", pbusy, 1);
    chk("rel_cmd_ready_held", cmd_ready, 0);
    @(posedge pclk);
    #1;
    chk("rel_pbusy_clear", pbusy, 0);
    chk("rel_cmd_ready", cmd_ready, 1);

    // zero-wait write, cycle-exact phases
    sl_wait = 0;
    send(1'b1, 10'h004, 32'hDEAD_BEEF, 33'h0);
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_penable", penable, 0);
    chk("wr_setup_state", dbg_state, APB_SETUP);
    chk("wr_paddr", paddr, 10'h004);
    chk("wr_pwrite", pwrite, 1);
    chk("wr_pwdata", pwdata, 32'hDEAD_BEEF);
    @(posedge pclk); #1;
    chk("wr_access_psel", psel, 1);
    chk("wr_access_penable", penable, 1);
    chk("wr_access_rsp_valid", rsp_valid, 0);
    @(posedge pclk); #1;
    chk("wr_done_psel", psel, 0);
    chk("wr_done_penable", penable, 0);
    chk("wr_done_rsp_valid", rsp_valid, 1);
    drain(50);

    // read with three wait states
    sl_wait = 3;
    send(1'b0, 10'h004, '0, {1'b0, 32'hDEAD_BEEF});
    drain(50);
    chk("rd_wait_access_len", acc_len, 4);

    // slave error, then normal traffic to the same address
    sl_wait = 0;
    sl_err  = 1'b1;
    send(1'b0, 10'h3FF, '0, {1'b1, 32'h0});
    drain(50);
    sl_err  = 1'b0;
    sl_wait = 1;
    send(1'b1, 10'h3FF, 32'h1234_5678, 33'h0);
    send(1'b0, 10'h3FF, '0, {1'b0, 32'h1234_5678});
    drain(50);

    // timeout: slave never ready
    sl_wait  = 0;
    sl_never = 1'b1;
    send(1'b0, 10'h008, '0, {1'b1, 32'h0});
    drain(100);
    chk("timeout_access_len", acc_len, 16);
    chk("timeout_psel", psel, 0);
    sl_never = 1'b0;

    // back-to-back writes with response backpressure
    wr_log.delete();
    send(1'b1, 10'd1, 32'hA000_0001, 33'h0);
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    chk("bp_rsp_valid", rsp_valid, 1);
    s0 = setup_cnt;
    exp_q.push_back(33'h0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'd2; cmd_wdata = 32'hA000_0002;
    repeat (6) begin
      @(negedge pclk);
      chk("bp_cmd_ready_low", cmd_ready, 0);
    end
    chk("bp_no_setup", setup_cnt, s0);
    chk("bp_rsp_held", rsp_valid, 1);
    @(posedge pclk); #1;
    rsp_ready = 1'b1;
    @(negedge pclk);
    chk("bp_same_cycle_accept", cmd_ready, 1);
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    for (int i = 3; i <= 5; i++) send(1'b1, AW'(i), 32'hA000_0000 + DW'(i), 33'h0);
    drain(100);
    chk("bp_write_count", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("bp_write_order", wr_log[i], i + 1);
    for (int i = 1; i <= 5; i++) send(1'b0, AW'(i), '0, {1'b0, 32'hA000_0000 + DW'(i)});
    drain(100);

    // reset in the middle of a transfer: abort, no response
    sl_never = 1'b1;
    send(1'b0, 10'h008, '0, {1'b1, 32'h0});
    repeat (3) @(posedge pclk);
    #1;
    presetn = 1'b0;
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_pbusy", pbusy, 1);
    chk("midrst_paddr", paddr, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    sl_never = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    repeat (20) @(posedge pclk);
    #1;
    chk("midrst_no_rsp", rsp_valid, 0);
    send(1'b1, 10'h002, 32'hCAFE_F00D, 33'h0);
    send(1'b0, 10'h002, '0, {1'b0, 32'hCAFE_F00D});
    drain(50);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
